// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: datapath widths, the no-op encoding
// and the IF/ID register layout used by fetch and the decode-side hazard logic.
package legv8_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

    // Redirect targets are word-aligned by dropping the low two bits.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return addr & ~(PC_W'(3));
    endfunction

endpackage

// File: rtl/fetch_ifid_if.sv
// Fetch-stage bus: hazard/branch controls and instruction memory in,
// IF/ID register contents and status out.
interface fetch_ifid_if;
    import legv8_pkg::*;

    logic                 stall;
    logic                 flush;
    logic                 pc_src;
    logic [PC_W-1:0]      branch_target;
    logic [PC_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]   imem_data;
    logic [PC_W-1:0]      if_id_pc;
    logic [INSTR_W-1:0]   if_id_instr;
    logic                 if_id_valid;
    logic                 misalign;
    logic [31:0]          fetch_count;

    // master: the fetch stage itself; slave: hazard unit, memory and decode.
    modport master (
        input  stall, flush, pc_src, branch_target, imem_data,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign, fetch_count
    );

    modport slave (
        output stall, flush, pc_src, branch_target, imem_data,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign, fetch_count
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter with async reset: takes the aligned branch target on a
// redirect, otherwise advances by one word when enabled.
module pc_reg
    import legv8_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            pc_src,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_next;

    always_comb begin
        pc_next = pc + PC_W'(4);
        if (pc_src) begin
            pc_next = align_word(branch_target);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (en) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_ifid.sv
// LEGv8 instruction fetch with the IF/ID pipeline register, redirect,
// stall and flush handling, misaligned-target flag and fetch counter.
module fetch_ifid
    import legv8_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ifid_if.master  bus
);

    logic [PC_W-1:0] pc;
    if_id_t          ifid_q;
    logic            misalign_q;
    logic [31:0]     cnt_q;
    logic            load_real;

    // An older redirecting branch must move the PC even while fetch is stalled.
    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .en            (!bus.stall || bus.pc_src),
        .pc_src        (bus.pc_src),
        .branch_target (bus.branch_target),
        .pc            (pc)
    );

    assign load_real = !bus.flush && !bus.stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_q <= IF_ID_BUBBLE;
        end else if (bus.flush) begin
            ifid_q <= IF_ID_BUBBLE;
        end else if (!bus.stall) begin
            ifid_q <= '{pc: pc, instr: bus.imem_data, valid: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (bus.pc_src && (bus.branch_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_real) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_id_pc    = ifid_q.pc;
    assign bus.if_id_instr = ifid_q.instr;
    assign bus.if_id_valid = ifid_q.valid;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed vector bench for fetch_ifid: a table of single-edge vectors
// plus hand sequences for async reset, counter wrap and PC wrap.
module tb_fetch_ifid;

    logic clk;
    logic reset;

    fetch_ifid_if b1 ();
    fetch_ifid_if b2 ();

    // Memory returns a word derived from its address so each fetch is distinct.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hF800_0000;
    endfunction

    assign b1.imem_data = mem_word(b1.imem_addr);
    assign b2.imem_data = mem_word(b2.imem_addr);

    fetch_ifid #(.RESET_PC(64'h100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.master)
    );

    fetch_ifid #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pc_src;
        logic [63:0] target;
        logic [63:0] e_addr;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    int nvec;
    int nfail;
    vec_t vecs [18];

    function automatic vec_t mk(input logic st, input logic fl, input logic ps,
                                input logic [63:0] tg, input logic [63:0] ea,
                                input logic [63:0] ep, input logic [31:0] ei,
                                input logic ev, input logic em, input logic [31:0] ec);
        vec_t v;
        v.stall = st; v.flush = fl; v.pc_src = ps; v.target = tg;
        v.e_addr = ea; v.e_pc = ep; v.e_instr = ei; v.e_valid = ev;
        v.e_mis = em; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] ea, input logic [63:0] ep,
                           input logic [31:0] ei, input logic ev, input logic em,
                           input logic [31:0] ec);
        chk({tag, ".imem_addr"},   b1.imem_addr,   ea);
        chk({tag, ".if_id_pc"},    b1.if_id_pc,    ep);
        chk({tag, ".if_id_instr"}, 64'(b1.if_id_instr), 64'(ei));
        chk({tag, ".if_id_valid"}, 64'(b1.if_id_valid), 64'(ev));
        chk({tag, ".misalign"},    64'(b1.misalign),    64'(em));
        chk({tag, ".fetch_count"}, 64'(b1.fetch_count), 64'(ec));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec  = 0;
        nfail = 0;

        //          st  fl  ps  target     addr       if_id_pc   instr                  v  mis cnt
        vecs[0]  = mk(0, 0, 0, 64'h0,   64'h104, 64'h100, mem_word(64'h100), 1, 0, 1);
        vecs[1]  = mk(0, 0, 0, 64'h0,   64'h108, 64'h104, mem_word(64'h104), 1, 0, 2);
        vecs[2]  = mk(0, 0, 0, 64'h0,   64'h10C, 64'h108, mem_word(64'h108), 1, 0, 3);
        vecs[3]  = mk(0, 0, 1, 64'h20,  64'h20,  64'h10C, mem_word(64'h10C), 1, 0, 4);
        vecs[4]  = mk(1, 0, 0, 64'h0,   64'h20,  64'h10C, mem_word(64'h10C), 1, 0, 4);
        vecs[5]  = mk(1, 0, 0, 64'h0,   64'h20,  64'h10C, mem_word(64'h10C), 1, 0, 4);
        vecs[6]  = mk(1, 0, 0, 64'h0,   64'h20,  64'h10C, mem_word(64'h10C), 1, 0, 4);
        vecs[7]  = mk(1, 0, 0, 64'h0,   64'h20,  64'h10C, mem_word(64'h10C), 1, 0, 4);
        vecs[8]  = mk(0, 0, 0, 64'h0,   64'h24,  64'h20,  mem_word(64'h20),  1, 0, 5);
        vecs[9]  = mk(1, 1, 1, 64'h400, 64'h400, 64'h0,   32'h0,             0, 0, 5);
        vecs[10] = mk(0, 0, 0, 64'h0,   64'h404, 64'h400, mem_word(64'h400), 1, 0, 6);
        vecs[11] = mk(0, 0, 1, 64'h402, 64'h400, 64'h404, mem_word(64'h404), 1, 1, 7);
        vecs[12] = mk(0, 0, 0, 64'h0,   64'h404, 64'h400, mem_word(64'h400), 1, 1, 8);
        vecs[13] = mk(0, 1, 1, 64'h800, 64'h800, 64'h0,   32'h0,             0, 1, 8);
        vecs[14] = mk(1, 1, 0, 64'h0,   64'h800, 64'h0,   32'h0,             0, 1, 8);
        vecs[15] = mk(0, 0, 0, 64'h0,   64'h804, 64'h800, mem_word(64'h800), 1, 1, 9);
        vecs[16] = mk(0, 1, 0, 64'h0,   64'h808, 64'h0,   32'h0,             0, 1, 9);
        vecs[17] = mk(0, 0, 0, 64'h0,   64'h80C, 64'h808, mem_word(64'h808), 1, 1, 10);

        reset = 1'b1;
        b1.stall = 1'b0; b1.flush = 1'b0; b1.pc_src = 1'b0; b1.branch_target = '0;
        b2.stall = 1'b1; b2.flush = 1'b0; b2.pc_src = 1'b0; b2.branch_target = '0;

        #1;
        chk_all("reset", 64'h100, 64'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            b1.stall         = vecs[i].stall;
            b1.flush         = vecs[i].flush;
            b1.pc_src        = vecs[i].pc_src;
            b1.branch_target = vecs[i].target;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Async reset mid-cycle while stalled with a valid IF/ID.
        b1.stall = 1'b1; b1.flush = 1'b0; b1.pc_src = 1'b0;
        @(posedge clk);
        #1;
        chk_all("stall_pre_rst", 64'h80C, 64'h808, mem_word(64'h808), 1'b1, 1'b1, 32'd10);
        #1;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 64'h100, 64'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        b1.stall = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_rst", 64'h104, 64'h100, mem_word(64'h100), 1'b1, 1'b0, 32'd1);

        // Counter wrap: preload the count while stalled, then fetch once.
        @(negedge clk);
        b1.stall = 1'b1;
        #1;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("cnt_preload", 64'(b1.fetch_count), 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        b1.stall = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt_wrap", 64'(b1.fetch_count), 64'h0);
        chk("cnt_wrap_pc", b1.if_id_pc, 64'h104);

        // PC wrap on the second instance, held at its reset PC so far.
        chk("pcwrap_hold", b2.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pcwrap_hold_valid", 64'(b2.if_id_valid), 64'h0);
        @(negedge clk);
        b2.stall = 1'b0;
        @(posedge clk);
        #1;
        chk("pcwrap_addr", b2.imem_addr, 64'h0);
        chk("pcwrap_ifid_pc", b2.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pcwrap_instr", 64'(b2.if_id_instr), 64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
        chk("pcwrap_cnt", 64'(b2.fetch_count), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_ifid.md
# fetch_ifid

Instruction-fetch stage with integrated IF/ID pipeline register for the LEGv8 pipeline. It holds the program counter, drives the instruction-memory address, and captures the fetched 32-bit instruction word plus its PC into the IF/ID register. Decode, including the immediate sign-extender, reads that register. The block also applies branch redirects, load-use stalls and control-hazard flushes.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `stall` input 1: hold PC and the IF/ID register (load-use hazard).
- `flush` input 1: replace the IF/ID contents with a bubble.
- `pc_src` input 1: branch taken (CBZ/CBNZ/B resolved downstream).
- `branch_target` input 64: redirect address, valid when `pc_src`=1.
- `imem_addr` output 64: equal to the current PC.
- `imem_data` input 32: combinational instruction-memory read of `imem_addr`.
- `if_id_pc` output 64: PC of the instruction held in IF/ID.
- `if_id_instr` output 32: instruction held in IF/ID; 32'h0 when it is a bubble.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `misalign` output 1: sticky flag; set by any redirect with `branch_target[1:0]`≠0.
- `fetch_count` output 32: count of real instructions loaded into IF/ID; wraps.

## Operation
- PC update, evaluated in priority order:
  - `reset` → `RESET_PC`.
  - `pc_src`=1 → `{branch_target[63:2],2'b00}`. This applies even when `stall`=1, because the redirecting branch is older than the stalled instruction.
  - `stall`=1 → hold.
  - Otherwise → PC+4, modulo 2^64 (wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0).
- IF/ID update, evaluated in priority order:
  - `reset` → bubble.
  - `flush`=1 → bubble. This applies even when `stall`=1.
  - `stall`=1 → hold all three fields.
  - Otherwise → {PC, `imem_data`, valid=1}.
- Bubble means: `if_id_instr`=32'h0, `if_id_pc`=64'h0, `if_id_valid`=0. Opcode 0 decodes as no-op, and the sign-extender yields 0 for it.
- `pc_src` does not flush by itself. The hazard unit asserts `flush` together with `pc_src` when the wrong-path instruction must be squashed.
- Misalignment:
  - The low two bits of `branch_target` are forced to 0.
  - `misalign` sets on the first edge with `pc_src`=1 and `branch_target[1:0]`≠0.
  - Once set, it holds until `reset`.
- `fetch_count` increments by 1 exactly when IF/ID loads a real instruction (no reset, no flush, no stall). It wraps 32'hFFFF_FFFF → 0.
- Reset values:
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC` immediately on assertion.
  - `if_id_pc` = 0, `if_id_instr` = 0, `if_id_valid` = 0.
  - `misalign` = 0, `fetch_count` = 0.
- Reset mid-operation: all state returns to the reset values asynchronously. The first real instruction, from `RESET_PC`, appears in IF/ID on the first rising edge after `reset` deasserts.

## Timing
- `imem_addr` is a direct register output with no combinational path from any input.
- Fetch latency is 1 cycle: the word at `imem_addr` in cycle N is on `if_id_instr` in cycle N+1.
- Redirect latency is 1 cycle: `pc_src` sampled at edge N gives `imem_addr`=target after edge N. The target instruction reaches IF/ID at edge N+1.
- Stalls last any number of cycles. Outputs stay bit-identical throughout and `fetch_count` is frozen.
- Simultaneous `stall`+`flush` with no `pc_src`: PC holds and IF/ID becomes a bubble. The held PC is refetched once the stall releases.
- Simultaneous `stall`+`pc_src`+`flush`: PC takes the target and IF/ID becomes a bubble.

## Structure
- Shared package `legv8_pkg` holds:
  - `NOP_INSTR` = 32'h0.
  - `PC_W` = 64, `INSTR_W` = 32.
  - the `if_id_t` struct {pc, instr, valid}, reused by the decode-side hazard logic.
- One sub-module, `pc_reg`: the PC register with async reset, enable (=!stall || pc_src) and next-PC mux.
- The IF/ID register, misalign flag and counter stay in `fetch_ifid`.

## Test plan
- Reset with `RESET_PC`=64'h100 and memory returning PC-derived words → `imem_addr`=100; after 3 edges, `if_id_pc`=108, `if_id_valid`=1, `fetch_count`=3.
- Stall for 4 cycles at PC=64'h20 → `imem_addr` held at 20, IF/ID unchanged, `fetch_count` unchanged; PC=64'h24 one edge after release.
- `pc_src`=1, `branch_target`=64'h400, `flush`=1 while stalled → next cycle `imem_addr`=400 and `if_id_instr`=0, valid=0; the following cycle `if_id_pc`=400.
- `branch_target`=64'h402 → `imem_addr`=400 and `misalign`=1; it stays 1 through later aligned redirects until `reset`.
- PC preloaded to 64'hFFFF_FFFF_FFFF_FFFC (via `RESET_PC`) → next `imem_addr`=0. Separately, force `fetch_count` to 32'hFFFF_FFFF; one more fetch yields 0.
- Assert `reset` asynchronously mid-cycle during a stall with valid IF/ID → all outputs take reset values before the next edge.
